// File: rtl/neokeon_decrypt_core.sv
// rtl/neokeon_decrypt_core.sv - iterative Neokeon-128 decryption engine, one round per clock
// Optional feature macro: NEOKEON_KEYCACHE_EN (adds reuseKey and a cached working key K')
module neokeon_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inDataState,
  input  logic [127:0] inKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outDataState,
`ifdef NEOKEON_KEYCACHE_EN
  input  logic         reuseKey,
`endif
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, KEYPREP, ROUND, FINAL, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] blk;
  logic [127:0] key;
  logic [127:0] kp;
  logic [4:0]   cnt;
  logic [7:0]   rc;
  logic         accept;
  logic         skip_keyprep;

  // Theta's diffusion step on one 32-bit word: t ^ rotl(t,8) ^ rotr(t,8)
  function automatic logic [31:0] mix(input logic [31:0] t);
    return t ^ {t[23:0], t[31:24]} ^ {t[7:0], t[31:8]};
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    t  = mix(a0 ^ a2);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[127:96];
    a1 = a1 ^ k[95:64];
    a2 = a2 ^ k[63:32];
    a3 = a3 ^ k[31:0];
    t  = mix(a1 ^ a3);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = s;
    return {a0, a1[30:0], a1[31], a2[26:0], a2[31:27], a3[29:0], a3[31:30]};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = s;
    return {a0, a1[0], a1[31:1], a2[4:0], a2[31:5], a3[1:0], a3[31:2]};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  // Decryption round: RC1 is always zero, so only the post-Theta constant is applied
  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic [7:0] c);
    return pi2(gamma(pi1(theta(s, k) ^ {24'h0, c, 96'h0})));
  endfunction

  // Inverse LFSR walks the round constants backwards: D4, 6A, 35, ... 1B, 80
  function automatic logic [7:0] rc_prev(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1B) >> 1) | 8'h80) : (r >> 1);
  endfunction

  assign inReady      = (state == IDLE) && !rst;
  assign accept       = inValid && inReady;
  assign outDataState = blk;

`ifdef NEOKEON_KEYCACHE_EN
  logic kp_valid;

  // Remember that kp holds a working key computed since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      kp_valid <= 1'b0;
    else if (state == KEYPREP)
      kp_valid <= 1'b1;
  end

  assign skip_keyprep = reuseKey && kp_valid;
`else
  assign skip_keyprep = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    outValid   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept)
          state_next = skip_keyprep ? ROUND : KEYPREP;
      end
      KEYPREP: state_next = ROUND;
      ROUND: begin
        if (cnt == 5'd1)
          state_next = FINAL;
      end
      FINAL: state_next = DONE;
      DONE: begin
        outValid = 1'b1;
        if (outReady)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch inputs, derive K', iterate rounds, apply final whitening
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
      key <= '0;
      kp  <= '0;
      cnt <= '0;
      rc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            blk <= inDataState;
            key <= inKey;
            cnt <= 5'd16;
            rc  <= 8'hD4;
          end
        end
        KEYPREP: begin
          kp  <= theta(key, 128'h0);
          cnt <= 5'd16;
          rc  <= 8'hD4;
        end
        ROUND: begin
          blk <= dec_round(blk, kp, rc);
          cnt <= cnt - 5'd1;
          rc  <= rc_prev(rc);
        end
        FINAL: begin
          // rc has stepped to Rcon[0] = 80 after the last round
          blk <= theta(blk, kp) ^ {24'h0, rc, 96'h0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neokeon_decrypt_core.sv
// tb/tb_neokeon_decrypt_core.sv - randomized round-trip bench for neokeon_decrypt_core
module tb_neokeon_decrypt_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [127:0] inDataState;
  logic [127:0] inKey;
  logic         outValid;
  logic         outReady;
  logic [127:0] outDataState;
  logic         busy;
`ifdef NEOKEON_KEYCACHE_EN
  logic         reuse_sel = 1'b0;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  localparam logic [7:0] RCON [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                       8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A,
                                       8'hD4};

  always #5 clk = ~clk;

  neokeon_decrypt_core dut (
    .clk(clk),
    .rst(rst),
    .inValid(inValid),
    .inReady(inReady),
    .inDataState(inDataState),
    .inKey(inKey),
    .outValid(outValid),
    .outReady(outReady),
    .outDataState(outDataState),
`ifdef NEOKEON_KEYCACHE_EN
    .reuseKey(reuse_sel),
`endif
    .busy(busy)
  );

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] m_theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
    t = a[0] ^ a[2];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] ^= t;
    a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[127 - 32*i -: 32];
    t = a[1] ^ a[3];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] ^= t;
    a[2] ^= t;
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] m_pi(input logic [127:0] s, input int n1, input int n2, input int n3);
    return {s[127:96], rl(s[95:64], n1), rl(s[63:32], n2), rl(s[31:0], n3)};
  endfunction

  function automatic logic [127:0] m_gamma(input logic [127:0] s);
    logic [31:0] a [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    t = a[3]; a[3] = a[0]; a[0] = t;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    return {a[0], a[1], a[2], a[3]};
  endfunction

  // Forward Neokeon encryption: the decrypt core must invert exactly this
  function automatic logic [127:0] m_encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s;
    s = p;
    for (int r = 0; r < 16; r++) begin
      s[103:96] = s[103:96] ^ RCON[r];
      s = m_theta(s, k);
      s = m_pi(s, 1, 5, 2);
      s = m_gamma(s);
      s = m_pi(s, 31, 27, 30);
    end
    s[103:96] = s[103:96] ^ RCON[16];
    return m_theta(s, k);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction; ok clears if inReady rises while busy, output moves under
  // backpressure, or a new block is taken in the cycle the output is consumed
  task automatic run(input logic [127:0] ct, input logic [127:0] k, input bit scramble,
                     input int hold, output logic [127:0] res, output int lat, output bit ok);
    int guard;
    guard = 0;
    while (!inReady && guard < 100) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    inValid = 1'b1;
    inDataState = ct;
    inKey = k;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    inValid = 1'b0;
    ok = 1'b1;
    while (!outValid && lat < 100) begin
      if (inReady || !busy) ok = 1'b0;
      if (scramble) begin
        inDataState = lat[0] ? '1 : '0;
        inKey       = lat[0] ? '1 : '0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = outDataState;
    for (int i = 0; i < hold; i++) begin
      inValid = 1'b1;
      inDataState = rnd128();
      @(posedge clk); @(negedge clk);
      if (outDataState !== res || !outValid || inReady || !busy) ok = 1'b0;
    end
    outReady = 1'b1;
    inValid = 1'b1;
    @(posedge clk); @(negedge clk);
    outReady = 1'b0;
    inValid = 1'b0;
    if (busy || !inReady || outValid) ok = 1'b0;
  endtask

  initial begin
    logic [127:0] p, k, res;
    int           lat;
    bit           ok;

    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    inDataState = '0;
    inKey = '0;
    repeat (3) @(negedge clk);
    chk("reset_inready", 128'(inReady), 128'(0));
    chk("reset_outvalid", 128'(outValid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_data", outDataState, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_inready", 128'(inReady), 128'(1));

    // Zero key / zero plaintext round trip
    run(m_encrypt('0, '0), '0, 1'b0, 0, res, lat, ok);
    chk("zero_pt", res, 128'h0);
    chk("zero_lat", 128'(lat), 128'(19));
    chk("zero_ok", 128'(ok), 128'(1));

    // Random pairs
    for (int t = 0; t < 1000; t++) begin
      p = rnd128();
      k = rnd128();
      run(m_encrypt(p, k), k, 1'b0, 0, res, lat, ok);
      chk("rand_pt", res, p);
      chk("rand_lat", 128'(lat), 128'(19));
      chk("rand_ok", 128'(ok), 128'(1));
    end

    // Backpressure: 50 cycles with outReady low and inValid pressing
    p = rnd128();
    k = rnd128();
    run(m_encrypt(p, k), k, 1'b0, 50, res, lat, ok);
    chk("bp_pt", res, p);
    chk("bp_stable", 128'(ok), 128'(1));

    // Inputs toggling after acceptance must not disturb the result
    p = rnd128();
    k = rnd128();
    run(m_encrypt(p, k), k, 1'b1, 0, res, lat, ok);
    chk("scramble_pt", res, p);
    chk("scramble_lat", 128'(lat), 128'(19));

    // Reset in the middle of ROUND (cycle 9)
    @(negedge clk);
    inValid = 1'b1;
    inDataState = rnd128();
    inKey = rnd128();
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst_outvalid", 128'(outValid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_inready", 128'(inReady), 128'(0));
    chk("midrst_data", outDataState, 128'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_inready", 128'(inReady), 128'(1));
    k = 128'h000102030405060708090A0B0C0D0E0F;
    p = rnd128();
    run(m_encrypt(p, k), k, 1'b0, 0, res, lat, ok);
    chk("post_rst_pt", res, p);
    chk("post_rst_lat", 128'(lat), 128'(19));

`ifdef NEOKEON_KEYCACHE_EN
    // Cached working key: second transaction skips KEYPREP
    k = rnd128();
    p = rnd128();
    reuse_sel = 1'b0;
    run(m_encrypt(p, k), k, 1'b0, 0, res, lat, ok);
    chk("cache_first_pt", res, p);
    p = rnd128();
    reuse_sel = 1'b1;
    run(m_encrypt(p, k), '0, 1'b0, 0, res, lat, ok);
    reuse_sel = 1'b0;
    chk("cache_reuse_pt", res, p);
    chk("cache_reuse_lat", 128'(lat), 128'(18));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
